// File: rtl/game_pkg.sv
// Shared types and codes for the game sequencer: state encodings, sound codes
// and a small helper used to size the frame counter.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    HIT       = 3'd3,
    GAMEOVER  = 3'd4
  } gameState_t;

  localparam logic [2:0] SFX_START = 3'd1;
  localparam logic [2:0] SFX_GOAL  = 3'd2;
  localparam logic [2:0] SFX_HIT   = 3'd3;
  localparam logic [2:0] SFX_OVER  = 3'd4;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_edge_det.sv
// Rising-edge detector; history resets high so a key held through reset
// never produces a spurious edge.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prevDin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prevDin <= 1'b1;
    else      prevDin <= din;
  end

  assign rise = din & ~prevDin;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: owns game state, lives and score, gates movement
// and scrolling, and issues one-cycle sound requests.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT       = 3,
  parameter int LIVES_W          = 2,
  parameter int SCORE_W          = 16,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int HIT_FRAMES       = 60,
  parameter int GAMEOVER_FRAMES  = 300,
  parameter int GRACE_FRAMES     = 90,
  parameter int SCORE_PERIOD     = 60,
  parameter int GOAL_PTS         = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               collision,
  input  logic               goal,
  output logic               move_en,
  output logic               scroll_en,
  output logic               sfx_en,
  output logic [2:0]         sfx_sel,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         state,
  output logic               paused
);

  localparam int MAX_FRAMES = maxOf(maxOf(maxOf(COUNTDOWN_FRAMES, HIT_FRAMES),
                                          maxOf(GAMEOVER_FRAMES, GRACE_FRAMES)),
                                    SCORE_PERIOD);
  localparam int FC_W = $clog2(MAX_FRAMES) + 1;

  gameState_t          stateReg;
  logic [FC_W-1:0]     fc;
  logic                startEdge, pauseEdge, goalEdge;
  logic                fcAdvance, survivalPt;
  logic [SCORE_W-1:0]  goalAdd, scoreNext;
  logic [SCORE_W:0]    scoreSum;

  edge_det startDet (.clk(clk), .rst(rst), .din(start_btn), .rise(startEdge));
  edge_det pauseDet (.clk(clk), .rst(rst), .din(pause_btn), .rise(pauseEdge));
  edge_det goalDet  (.clk(clk), .rst(rst), .din(goal),      .rise(goalEdge));

  // Score candidate: one extra bit catches overflow so the sum can saturate.
  always_comb begin
    fcAdvance  = frame_tick && !paused && (fc != '1);
    survivalPt = frame_tick && !paused && (fc != '0) &&
                 ((fc % FC_W'(SCORE_PERIOD)) == '0);
    goalAdd    = (goalEdge && !paused) ? SCORE_W'(GOAL_PTS) : '0;
    scoreSum   = {1'b0, score} + {1'b0, goalAdd} + (SCORE_W+1)'(survivalPt);
    scoreNext  = scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
  end

  // Game FSM; every transition also clears the frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= IDLE;
      fc       <= '0;
      lives    <= '0;
      score    <= '0;
      paused   <= 1'b0;
      sfx_en   <= 1'b0;
      sfx_sel  <= '0;
    end else begin
      sfx_en  <= 1'b0;
      sfx_sel <= '0;
      if (fcAdvance) fc <= fc + 1'b1;
      case (stateReg)
        IDLE: if (startEdge) begin
          stateReg <= COUNTDOWN;
          fc       <= '0;
          lives    <= LIVES_W'(LIVES_INIT);
          score    <= '0;
          sfx_en   <= 1'b1;
          sfx_sel  <= SFX_START;
        end
        COUNTDOWN: if (fc == FC_W'(COUNTDOWN_FRAMES)) begin
          stateReg <= PLAY;
          fc       <= '0;
        end
        PLAY: begin
          // A pause edge wins over collision and scoring in the same cycle.
          if (pauseEdge) begin
            paused <= ~paused;
          end else if (!paused && collision && fc >= FC_W'(GRACE_FRAMES)) begin
            stateReg <= HIT;
            fc       <= '0;
            paused   <= 1'b0;
            lives    <= (lives != '0) ? lives - 1'b1 : lives;
            sfx_en   <= 1'b1;
            sfx_sel  <= SFX_HIT;
          end else if (!paused) begin
            score <= scoreNext;
            if (goalEdge) begin
              sfx_en  <= 1'b1;
              sfx_sel <= SFX_GOAL;
            end
          end
        end
        HIT: if (fc == FC_W'(HIT_FRAMES)) begin
          fc     <= '0;
          sfx_en <= 1'b1;
          if (lives == '0) begin
            stateReg <= GAMEOVER;
            sfx_sel  <= SFX_OVER;
          end else begin
            stateReg <= COUNTDOWN;
            sfx_sel  <= SFX_START;
          end
        end
        GAMEOVER: if (fc == FC_W'(GAMEOVER_FRAMES) || startEdge) begin
          stateReg <= IDLE;
          fc       <= '0;
        end
        default: begin
          stateReg <= IDLE;
          fc       <= '0;
          paused   <= 1'b0;
        end
      endcase
    end
  end

  assign state     = stateReg;
  assign move_en   = (stateReg == PLAY) && !paused;
  assign scroll_en = (stateReg == IDLE) || ((stateReg == PLAY) && !paused);

endmodule
